fpmul_collect: RTL and testbench
================================

FPMUL_COLLECT -- requirements
Module: fpmul_collect

Interface
REQ-001 SHALL have parameter LAT, default 15, fpmul pipeline latency in cycles from operand presentation to registered out/overflow/sub.
REQ-002 SHALL have parameter DEPTH, default 8, result FIFO entries (power of two, 2..16).
REQ-003 SHALL have port CLK  input  1  single clock; all state on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  issuer presents an operand pair to fpmul this cycle.
REQ-006 SHALL have port in_ready  output  1  collector guarantees a FIFO slot for a pair issued this cycle.
REQ-007 SHALL have port mul_out  input  16  fpmul out (fp16 product).
REQ-008 SHALL have port mul_ovf  input  1  fpmul overflow flag.
REQ-009 SHALL have port mul_sub  input  1  fpmul sub (zero/subnormal exponent) flag.
REQ-010 SHALL have port o_valid  output  1  FIFO head valid.
REQ-011 SHALL have port o_ready  input  1  consumer accepts head.
REQ-012 SHALL have port o_data  output  18  {ovf, sub, product[15:0]} at FIFO head.
REQ-013 SHALL have port ovf_cnt  output  8  saturating count of pushed results with ovf=1.
REQ-014 SHALL have port sub_cnt  output  8  saturating count of pushed results with sub=1.
REQ-015 SHALL have port err  output  1  sticky: a result arrived while the FIFO was full and was dropped.

Function
REQ-016 SHALL define accept = in_valid & in_ready; in_valid with in_ready=0 SHALL be ignored (no tag, no credit used).
REQ-017 SHALL shift accept into a LAT-bit tag delay line each cycle; tap = delay line bit LAT-1, asserted exactly LAT cycles after the accepting edge.
REQ-018 SHALL push {mul_ovf, mul_sub, mul_out} sampled in the cycle tap=1; mul_* SHALL be ignored in any cycle tap=0, including X on mul_sub.
REQ-019 SHALL keep inflight = number of 1s in the delay line, updated as +accept -tap in the same cycle.
REQ-020 SHALL drive in_ready = ((inflight + count) < DEPTH), combinational from registered state; in_ready is 1 out of reset.
REQ-021 SHALL pop when o_valid & o_ready; o_valid = (count != 0); o_data = head entry, registered storage, no bypass (push visible on o_valid the next cycle).
REQ-022 SHALL handle push and pop in the same cycle: count unchanged, both pointers advance, legal when full.
REQ-023 SHALL, on push while count == DEPTH with no simultaneous pop, drop the entry, leave FIFO unchanged and set err=1 until reset.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; count range 0..DEPTH.
REQ-025 SHALL increment ovf_cnt / sub_cnt by 1 on each non-dropped push carrying the flag, saturating at 255; both may increment in the same cycle.
REQ-026 SHALL add no combinational path from mul_* to any output.

Reset
REQ-027 SHALL, on RST low at any time, asynchronously clear delay line, inflight, pointers, count, ovf_cnt, sub_cnt, err; o_valid=0, o_data=0, in_ready=1.
REQ-028 SHALL discard results of pairs in flight at reset; fpmul outputs during the first LAT cycles after reset release produce no push.

Verification
REQ-029 SHALL cover: single accept at cycle 0 (a=0x3C00, b=0x4000), mul_out=0x4000 driven at cycle 15 -> o_valid=1 at cycle 16, o_data=0x04000, ovf_cnt=0.
REQ-030 SHALL cover: in_valid held 1, o_ready=0, DEPTH=8 -> exactly 8 accepts, in_ready=0 from cycle 8, 8 entries in FIFO by cycle 23, err=0.
REQ-031 SHALL cover: full FIFO, o_ready=1 for one cycle with simultaneous push -> count stays 8, head advances, pushed entry readable last in order.
REQ-032 SHALL cover: forced push (tap) with FIFO full and o_ready=0 -> entry dropped, err=1 and remains 1 until RST low.
REQ-033 SHALL cover: 300 results with mul_ovf=1, mul_out=0x7FFF -> ovf_cnt=255, sub_cnt=0; results with mul_sub=1, mul_out=0x0000 -> sub_cnt counts each.
REQ-034 SHALL cover: RST low mid-stream with 5 in flight and 3 queued -> o_valid=0, in_ready=1 immediately; no push in the LAT cycles after release with mul_out toggling.

Source files
------------

// File: rtl/fpmul_collect.sv
// fpmul_collect: result collector for a fixed-latency fp16 multiplier.
//
// The issuer presents operand pairs to the multiplier; this block tracks each
// accepted pair with a tag travelling down a LAT-deep delay line, captures the
// multiplier outputs when the tag emerges, and queues them in a DEPTH-entry
// FIFO. Credits (in-flight tags plus queued entries) gate in_ready, so a
// result always has a slot.
//
// Ports:
//   CLK, RST       clock (posedge) and asynchronous active-low reset
//   in_valid       issuer presents an operand pair this cycle
//   in_ready       a FIFO slot is guaranteed for a pair issued this cycle
//   mul_out        fp16 product from the multiplier (sampled only at tap)
//   mul_ovf        multiplier overflow flag (sampled only at tap)
//   mul_sub        multiplier zero/subnormal flag (sampled only at tap)
//   o_valid        FIFO head valid
//   o_ready        consumer accepts the head
//   o_data         {ovf, sub, product[15:0]} at the FIFO head
//   ovf_cnt        saturating count of queued results with ovf set
//   sub_cnt        saturating count of queued results with sub set
//   err            sticky: a result arrived with the FIFO full and was lost
module fpmul_collect #(
  parameter int LAT   = 15,
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] mul_out,
  input  logic        mul_ovf,
  input  logic        mul_sub,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [17:0] o_data,
  output logic [7:0]  ovf_cnt,
  output logic [7:0]  sub_cnt,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = ((IW > CW) ? IW : CW) + 1;

  logic [LAT-1:0] tags;
  logic [IW-1:0]  inflight;
  logic [CW-1:0]  count;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [17:0]    mem [DEPTH];

  logic          tap;
  logic          accept;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [SW-1:0] occupancy;

  assign tap       = tags[LAT-1];
  assign full      = (count == CW'(DEPTH));
  assign occupancy = SW'(inflight) + SW'(count);
  assign in_ready  = (occupancy < SW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign o_valid   = (count != '0);
  assign pop       = o_valid & o_ready;
  // A slot freed by a same-cycle pop is reusable, so a full FIFO still
  // accepts a result when the head leaves in the same cycle.
  assign push_ok   = tap & (~full | pop);
  // Gate the head with o_valid so o_data reads zero when empty without the
  // storage array itself needing a reset.
  assign o_data    = o_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tags     <= '0;
      inflight <= '0;
    end else begin
      tags     <= (tags << 1) | LAT'(accept);
      inflight <= inflight + IW'(accept) - IW'(tap);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because o_data is masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= {mul_ovf, mul_sub, mul_out};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_cnt <= '0;
      sub_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (push_ok && mul_ovf && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
      if (push_ok && mul_sub && (sub_cnt != 8'hFF)) sub_cnt <= sub_cnt + 8'd1;
      if (tap && full && !pop)                      err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpmul_collect.sv
// Self-checking bench for fpmul_collect. A behavioural multiplier pipeline
// in the bench returns each accepted pair's product LAT cycles later; the
// expected FIFO contents live in a scoreboard queue.
module tb_fpmul_collect;

  localparam int LAT   = 15;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mul_out = '0;
  logic        mul_ovf = 1'b0;
  logic        mul_sub = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [17:0] o_data;
  logic [7:0]  ovf_cnt;
  logic [7:0]  sub_cnt;
  logic        err;

  fpmul_collect #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .mul_out(mul_out), .mul_ovf(mul_ovf), .mul_sub(mul_sub),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .ovf_cnt(ovf_cnt), .sub_cnt(sub_cnt), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    logic        ovf;
    logic        sub;
  } vec_t;

  typedef logic [17:0] res_t;

  vec_t vecs [8];
  res_t exp_q [$];
  logic pv [LAT];
  res_t pd [LAT];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_ovf = 0;
  int   m_sub = 0;
  logic m_err = 1'b0;
  bit   chk_ready = 1'b1;
  bit   force_tap = 1'b0;
  res_t force_res = '0;
  res_t next_res = '0;
  int   accepts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    m_ovf = 0;
    m_sub = 0;
    m_err = 1'b0;
    chk_ready = 1'b1;
  endtask

  // One clock cycle: drive the multiplier outputs, check handshake outputs,
  // score pops and pushes, advance the bench pipeline, then take the edge.
  task automatic step();
    logic tap_v;
    res_t tap_d;
    logic acc;
    logic pop;
    int   infl;
    int   sz;
    @(negedge CLK);
    tap_v = pv[LAT-1] | force_tap;
    tap_d = force_tap ? force_res : pd[LAT-1];
    if (tap_v) begin
      {mul_ovf, mul_sub, mul_out} = tap_d;
    end else begin
      mul_out = 16'($urandom);
      mul_ovf = 1'($urandom);
      mul_sub = 1'($urandom);
    end
    infl = 0;
    for (int i = 0; i < LAT; i++) infl += int'(pv[i]);
    sz = exp_q.size();
    check("o_valid", 32'(o_valid), 32'(sz != 0));
    if (chk_ready) check("in_ready", 32'(in_ready), 32'((infl + sz) < DEPTH));
    acc = in_valid & in_ready;
    pop = o_valid & o_ready;
    if (acc) accepts++;
    if (pop && sz != 0) check("o_data", 32'(o_data), 32'(exp_q.pop_front()));
    if (tap_v) begin
      if (sz == DEPTH && !pop) begin
        m_err = 1'b1;
      end else begin
        exp_q.push_back(tap_d);
        if (tap_d[17] && m_ovf < 255) m_ovf++;
        if (tap_d[16] && m_sub < 255) m_sub++;
      end
    end
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = acc;
    pd[0] = next_res;
    if (force_tap) force dut.tap = 1'b1;
    @(posedge CLK);
    #1;
    if (force_tap) begin
      release dut.tap;
      force_tap = 1'b0;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_o_valid"},  32'(o_valid),  32'd0);
    check({tag, "_o_data"},   32'(o_data),   32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_ovf_cnt"},  32'(ovf_cnt),  32'd0);
    check({tag, "_sub_cnt"},  32'(sub_cnt),  32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  // Asynchronous reset asserted away from any clock edge, released on a
  // falling edge.
  task automatic do_reset(input string tag);
    #3;
    RST = 1'b0;
    #1;
    reset_checks(tag);
    clear_model();
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int guard;

    //              a         b         prod      ovf   sub
    vecs[0] = '{16'h3C00, 16'h4000, 16'h4000, 1'b0, 1'b0};
    vecs[1] = '{16'h4000, 16'h4000, 16'h4400, 1'b0, 1'b0};
    vecs[2] = '{16'h3E00, 16'h3E00, 16'h4080, 1'b0, 1'b0};
    vecs[3] = '{16'hBC00, 16'h4200, 16'hC200, 1'b0, 1'b0};
    vecs[4] = '{16'h3800, 16'h3800, 16'h3400, 1'b0, 1'b0};
    vecs[5] = '{16'h7BFF, 16'h4000, 16'h7FFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h8400, 16'h3800, 16'h8200, 1'b0, 1'b1};
    clear_model();

    // Reset state.
    #12;
    reset_checks("rst");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Single accept: result visible LAT+1 cycles after the accept cycle.
    o_ready  = 1'b0;
    in_valid = 1'b1;
    next_res = {vecs[0].ovf, vecs[0].sub, vecs[0].prod};
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("first_latency", 32'(cyc), 32'(LAT + 1));
    check("first_data", 32'(o_data), 32'h04000);
    check("first_ovf_cnt", 32'(ovf_cnt), 32'd0);
    o_ready = 1'b1;
    step();

    // Table of products streamed with a free-running consumer.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      next_res = {vecs[i].ovf, vecs[i].sub, vecs[i].prod};
      step();
    end
    in_valid = 1'b0;
    repeat (LAT + 3) step();
    check("table_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    check("table_sub_cnt", 32'(sub_cnt), 32'(m_sub));

    // Fill with a stalled consumer: exactly DEPTH accepts.
    o_ready  = 1'b0;
    in_valid = 1'b1;
    accepts  = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 7) check("fill_ready_c7", 32'(in_ready), 32'd1);
      if (c == 8) check("fill_ready_c8", 32'(in_ready), 32'd0);
      next_res = {2'b00, 16'(16'h3C00 + c)};
      step();
    end
    in_valid = 1'b0;
    check("fill_accepts", 32'(accepts), 32'(DEPTH));
    check("fill_count", 32'(dut.count), 32'(DEPTH));
    check("fill_err", 32'(err), 32'd0);

    // Forced result while full with a simultaneous pop: count holds.
    chk_ready = 1'b0;
    o_ready   = 1'b1;
    force_res = {2'b00, 16'hABCD};
    force_tap = 1'b1;
    step();
    o_ready = 1'b0;
    check("full_pushpop_count", 32'(dut.count), 32'(DEPTH));

    // Forced result while full with no pop: dropped, err sticks.
    force_res = {2'b11, 16'h1234};
    force_tap = 1'b1;
    step();
    check("drop_err", 32'(err), 32'(m_err));
    check("drop_count", 32'(dut.count), 32'(DEPTH));
    check("drop_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    repeat (3) step();
    o_ready = 1'b1;
    repeat (DEPTH + 2) step();
    check("drop_err_sticky", 32'(err), 32'd1);
    do_reset("rst2");

    // Saturating overflow counter, then subnormal counter.
    o_ready  = 1'b1;
    accepts  = 0;
    guard    = 0;
    next_res = {2'b10, 16'h7FFF};
    while (accepts < 300 && guard < 20000) begin
      in_valid = 1'b1;
      step();
      guard++;
    end
    check("sat_accepts", 32'(accepts), 32'd300);
    accepts  = 0;
    next_res = {2'b01, 16'h0000};
    while (accepts < 5 && guard < 20000) begin
      in_valid = 1'b1;
      step();
      guard++;
    end
    in_valid = 1'b0;
    repeat (LAT + 3) step();
    check("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);
    check("sat_sub_cnt", 32'(sub_cnt), 32'd5);
    check("sat_err", 32'(err), 32'd0);

    // Reset mid-stream with 3 queued and 5 in flight.
    o_ready  = 1'b0;
    accepts  = 0;
    next_res = {2'b00, 16'h4200};
    while (accepts < 3) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    check("mid_count", 32'(dut.count), 32'd3);
    accepts  = 0;
    next_res = {2'b10, 16'h7C00};
    while (accepts < 5) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    do_reset("rst3");
    repeat (LAT + 5) step();
    check("post_rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("post_rst_sub_cnt", 32'(sub_cnt), 32'd0);

    // One more transaction after reset.
    o_ready  = 1'b1;
    in_valid = 1'b1;
    next_res = {vecs[7].ovf, vecs[7].sub, vecs[7].prod};
    step();
    in_valid = 1'b0;
    repeat (LAT + 3) step();
    check("final_sub_cnt", 32'(sub_cnt), 32'(m_sub));
    check("final_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
